write_req_queue: RTL

Host-side front end for the DDR write path. Accepts flat write requests over a valid/ready handshake and buffers them in a small FIFO. Decodes each address into bank/row/column and replays the requests one at a time into the `Write` command state machine directly downstream. `Write` has no completion output, so this block paces issue with fixed-length strobe and gap counters.

---
 rtl/write_req_queue.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/write_req_queue.sv
// write_req_queue
//   Host-side front end for the DDR write path. Buffers flat write requests in
//   a small FIFO, decodes each address into bank/row/column and replays the
//   requests one at a time into the downstream Write command FSM. Issue is
//   paced by fixed strobe (ISSUE_CYCLES) and gap (GAP_CYCLES) counters.
//
//   Optional feature macro: WRQ_BURST_CHOP_EN
//     defined   : A_12 = !bc of the popped entry (bc=1 requests BC4).
//     undefined : A_12 tied to 1 (BL8), req_bc ignored, 45-bit FIFO entry.
//
//   Ports
//     clk, areset          rising-edge clock, async active-high reset
//     req_valid/req_ready  host handshake (ready depends on registered state only)
//     req_addr[27:0]       {bank[27:25], row[24:10], col[9:0]}
//     req_data[15:0]       write data
//     req_ap, req_bc       auto-precharge / burst-chop request
//     in, in_p             issue strobe and auto-precharge select to Write
//     Addr_Row, Addr_Column, Addr_Column_11, A_10, A_12, BA_in, DQ_in
//                          decoded command fields, stable from pop to next pop
//     busy                 FSM not idle or FIFO non-empty
//     level                FIFO occupancy
`timescale 1ns/1ps

module write_req_queue #(
    parameter int DEPTH        = 4,
    parameter int ISSUE_CYCLES = 2,
    parameter int GAP_CYCLES   = 5
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [27:0]                req_addr,
    input  logic [15:0]                req_data,
    input  logic                       req_ap,
    input  logic                       req_bc,
    output logic                       in,
    output logic                       in_p,
    output logic [14:0]                Addr_Row,
    output logic [9:0]                 Addr_Column,
    output logic                       Addr_Column_11,
    output logic                       A_10,
    output logic                       A_12,
    output logic [3:0]                 BA_in,
    output logic [15:0]                DQ_in,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int CMAX = (ISSUE_CYCLES > GAP_CYCLES) ? ISSUE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
`ifdef WRQ_BURST_CHOP_EN
    localparam int EW   = 46;
`else
    localparam int EW   = 45;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic            w_ready;
    logic            r_ready_en;

    logic [EW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [EW-1:0]   w_wr_entry;
    logic [EW-1:0]   w_head;

    logic            r_in;
    logic            r_ap;
    logic [14:0]     r_row;
    logic [9:0]      r_col;
    logic [2:0]      r_bank;
    logic [15:0]     r_dq;

`ifdef WRQ_BURST_CHOP_EN
    logic            r_a12;
    assign w_wr_entry = {req_addr, req_data, req_ap, req_bc};
`else
    logic            w_unused_bc;
    assign w_unused_bc = req_bc;
    assign w_wr_entry  = {req_addr, req_data, req_ap};
`endif

    // r_ready_en holds ready low until the first edge after reset is released.
    assign w_ready   = r_ready_en && (r_level < LW'(DEPTH)) && !areset;
    assign w_push    = req_valid && w_ready;
    assign w_head    = r_mem[r_rd_ptr];

    // ---------------- FIFO ----------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_level != '0) begin
                    w_pop       = 1'b1;
                    w_cnt_nxt   = CW'(ISSUE_CYCLES);
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt <= CW'(1)) begin
                    if (GAP_CYCLES == 0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt   = CW'(GAP_CYCLES);
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt <= CW'(1)) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_issue = (r_state == ST_ISSUE);
    end

    // The strobe is registered from the ISSUE state, so it rises one edge after
    // the pop, when the decoded fields have already settled.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_in   <= 1'b0;
            r_ap   <= 1'b0;
            r_row  <= '0;
            r_col  <= '0;
            r_bank <= '0;
            r_dq   <= '0;
`ifdef WRQ_BURST_CHOP_EN
            r_a12  <= 1'b1;
`endif
        end else begin
            r_in <= w_issue;
            if (w_pop) begin
                r_bank <= w_head[EW-1 -: 3];
                r_row  <= w_head[EW-4 -: 15];
                r_col  <= w_head[EW-19 -: 10];
                r_dq   <= w_head[EW-29 -: 16];
                r_ap   <= w_head[EW-45];
`ifdef WRQ_BURST_CHOP_EN
                r_a12  <= !w_head[0];
`endif
            end
        end
    end

    assign req_ready      = w_ready;
    assign in             = r_in;
    assign in_p           = r_ap;
    assign A_10           = r_ap;
    assign Addr_Row       = r_row;
    assign Addr_Column    = r_col;
    assign Addr_Column_11 = 1'b0;
    assign BA_in          = {1'b0, r_bank};
    assign DQ_in          = r_dq;
`ifdef WRQ_BURST_CHOP_EN
    assign A_12           = r_a12;
`else
    assign A_12           = 1'b1;
`endif
    assign busy           = (r_state != ST_IDLE) || (r_level != '0);
    assign level          = r_level;

endmodule
